// File: rtl/stopwatch_pkg.sv
// ------------------------------------------------------------------
// stopwatch_pkg : shared digit radices, widths and radix lookup
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  localparam int RADIX_EVEN = 10;
  localparam int RADIX_ODD  = 6;
  localparam int BCD_W      = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Even positions are units (0-9), odd positions are tens (0-5).
  function automatic int radix_of(input int index);
    return ((index % 2) != 0) ? RADIX_ODD : RADIX_EVEN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_core_bcd_digit.sv
// ------------------------------------------------------------------
// bcd_digit : one mod-RADIX counter digit with load, inc/dec, carry/borrow
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  bcd_t i_load_val,
  input  logic i_inc,
  input  logic i_dec,
  output bcd_t o_val,
  output logic o_carry,
  output logic o_borrow
);

  localparam bcd_t c_MAX = bcd_t'(RADIX - 1);

  bcd_t r_val;
  bcd_t w_load_val;

  // Out-of-range writes saturate to the largest legal digit value.
  assign w_load_val = (i_load_val > c_MAX) ? c_MAX : i_load_val;
  assign o_carry    = i_inc & (r_val == c_MAX);
  assign o_borrow   = i_dec & (r_val == '0);
  assign o_val      = r_val;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= w_load_val;
    end else if (i_inc) begin
      r_val <= o_carry ? '0 : r_val + 1'b1;
    end else if (i_dec) begin
      r_val <= o_borrow ? c_MAX : r_val - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_core.sv
// ------------------------------------------------------------------
// stopwatch_core : BCD up/down stopwatch with prescaler, lap hold and digit adjust
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100_000_000,
  localparam int SEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start_stop,
  input  logic                        i_clear,
  input  logic                        i_lap,
  input  logic                        i_down,
  input  logic                        i_adj,
  input  logic [SEL_W-1:0]            i_adj_sel,
  input  logic                        i_adj_we,
  input  logic [BCD_W-1:0]            i_adj_val,
  output logic [BCD_W*NUM_DIGITS-1:0] o_count,
  output logic [BCD_W*NUM_DIGITS-1:0] o_digits,
  output logic                        o_running,
  output logic                        o_lap_active,
  output logic                        o_tick,
  output logic                        o_expired
);

  localparam int                 c_CNT_W    = BCD_W * NUM_DIGITS;
  localparam int                 c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

  logic [c_PRE_W-1:0] r_pre;
  logic               r_run;
  logic               r_lap_act;
  logic [c_CNT_W-1:0] r_lap;
  logic               r_tick;
  logic               r_expired;

  logic [c_CNT_W-1:0] w_count;
  logic [NUM_DIGITS:0] w_cy;
  logic [NUM_DIGITS:0] w_bw;
  logic               w_running;
  logic               w_wr;
  logic               w_pre_term;
  logic               w_step;
  logic               w_hit_zero;
  logic               w_ss_ok;
  logic               w_unused;

  assign w_running  = r_run & ~i_adj;
  assign w_wr       = i_adj & i_adj_we;
  assign w_pre_term = w_running && (r_pre == c_PRE_LAST);
  assign w_step     = w_pre_term & ~i_clear & ~w_wr;
  // A single BCD decrement lands on all-zero only from the value 1.
  assign w_hit_zero = w_step & i_down & (w_count == c_ONE);
  assign w_ss_ok    = i_start_stop & ~i_adj & ~(i_down & (w_count == '0));

  assign w_cy[0]  = w_step & ~i_down;
  assign w_bw[0]  = w_step & i_down;
  assign w_unused = w_cy[NUM_DIGITS] | w_bw[NUM_DIGITS];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit #(
      .RADIX (radix_of(k))
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (i_clear),
      .i_load     (w_wr && (i_adj_sel == SEL_W'(k))),
      .i_load_val (i_adj_val),
      .i_inc      (w_cy[k]),
      .i_dec      (w_bw[k]),
      .o_val      (w_count[k*BCD_W +: BCD_W]),
      .o_carry    (w_cy[k+1]),
      .o_borrow   (w_bw[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre     <= '0;
      r_run     <= 1'b0;
      r_lap_act <= 1'b0;
      r_lap     <= '0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_tick    <= w_step;
      r_expired <= w_hit_zero;
      if (i_clear) begin
        r_pre     <= '0;
        r_run     <= 1'b0;
        r_lap_act <= 1'b0;
      end else begin
        if (w_running) begin
          r_pre <= w_pre_term ? '0 : r_pre + 1'b1;
        end
        if (w_hit_zero) begin
          r_run <= 1'b0;
        end else if (w_ss_ok) begin
          r_run <= ~r_run;
        end
        if (i_lap) begin
          r_lap_act <= ~r_lap_act;
          if (!r_lap_act) begin
            r_lap <= w_count;
          end
        end
      end
    end
  end

  assign o_count      = w_count;
  assign o_digits     = r_lap_act ? r_lap : w_count;
  assign o_running    = w_running;
  assign o_lap_active = r_lap_act;
  assign o_tick       = r_tick;
  assign o_expired    = r_expired;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_core.sv
// ------------------------------------------------------------------
// tb_stopwatch_core : scoreboard bench for stopwatch_core (4 digit /4 and 6 digit /1)
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_core;

  typedef struct packed {
    logic [15:0] count;
    logic        expired;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        a_ss, a_clr, a_lap, a_down, a_adj, a_we;
  logic [1:0]  a_sel;
  logic [3:0]  a_val;
  logic [15:0] a_count, a_digits;
  logic        a_running, a_lap_active, a_tick, a_expired;

  logic        b_ss, b_clr, b_lap, b_down, b_adj, b_we;
  logic [2:0]  b_sel;
  logic [3:0]  b_val;
  logic [23:0] b_count, b_digits;
  logic        b_running, b_lap_active, b_tick, b_expired;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ticks_a = 0;
  int   n_exp_a   = 0;
  int   n_ticks_b = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  stopwatch_core #(.NUM_DIGITS(4), .TICK_DIV(4)) u_dut_a (
    .clk(clk), .rst(rst), .i_start_stop(a_ss), .i_clear(a_clr), .i_lap(a_lap),
    .i_down(a_down), .i_adj(a_adj), .i_adj_sel(a_sel), .i_adj_we(a_we), .i_adj_val(a_val),
    .o_count(a_count), .o_digits(a_digits), .o_running(a_running),
    .o_lap_active(a_lap_active), .o_tick(a_tick), .o_expired(a_expired)
  );

  stopwatch_core #(.NUM_DIGITS(6), .TICK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .i_start_stop(b_ss), .i_clear(b_clr), .i_lap(b_lap),
    .i_down(b_down), .i_adj(b_adj), .i_adj_sel(b_sel), .i_adj_we(b_we), .i_adj_val(b_val),
    .o_count(b_count), .o_digits(b_digits), .o_running(b_running),
    .o_lap_active(b_lap_active), .o_tick(b_tick), .o_expired(b_expired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] cnt, input logic exp);
    exp_t e;
    e.count   = cnt;
    e.expired = exp;
    sb_q.push_back(e);
  endtask

  task automatic a_write(input logic [1:0] sel, input logic [3:0] val);
    a_sel = sel; a_val = val; a_we = 1'b1;
    cyc(1);
    a_we = 1'b0;
  endtask

  task automatic b_write(input logic [2:0] sel, input logic [3:0] val);
    b_sel = sel; b_val = val; b_we = 1'b1;
    cyc(1);
    b_we = 1'b0;
  endtask

  function automatic logic [15:0] to_bcd4(input int secs);
    int s, mm, ss;
    s  = secs % 3600;
    mm = s / 60;
    ss = s % 60;
    return 16'(((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10));
  endfunction

  // Monitor: every tick/expired pulse of DUT A consumes one scoreboard entry.
  always @(negedge clk) begin
    if (a_tick === 1'b1 || a_expired === 1'b1) begin
      exp_t e;
      if (a_tick === 1'b1) n_ticks_a++;
      if (a_expired === 1'b1) n_exp_a++;
      check("sb_entry_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_tick_count", 32'(a_count), 32'(e.count));
        check("sb_tick_expired", 32'(a_expired), 32'(e.expired));
        check("sb_tick_pulse", 32'(a_tick), 32'd1);
      end
    end
    if (b_tick === 1'b1) n_ticks_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e0;
    rst = 1'b1;
    {a_ss, a_clr, a_lap, a_down, a_adj, a_we} = '0;
    a_sel = '0; a_val = '0;
    {b_ss, b_clr, b_lap, b_down, b_adj, b_we} = '0;
    b_sel = '0; b_val = '0;
    cyc(2);
    check("rst_count", 32'(a_count), 32'h0);
    check("rst_digits", 32'(a_digits), 32'h0);
    check("rst_flags", 32'({a_running, a_lap_active, a_tick, a_expired}), 32'h0);
    check("rst_count_b", 32'(b_count), 32'h0);
    rst = 1'b0;

    // Count up one minute.
    for (int i = 1; i <= 60; i++) push_exp(to_bcd4(i), 1'b0);
    t0 = n_ticks_a; e0 = n_exp_a;
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(240);
    check("up_count_0100", 32'(a_count), 32'h0100);
    check("up_running", 32'(a_running), 32'd1);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(1);
    check("up_tick_total", 32'(n_ticks_a - t0), 32'd60);
    check("up_no_expired", 32'(n_exp_a - e0), 32'd0);
    check("up_stopped", 32'(a_running), 32'd0);
    check("up_sb_drained", 32'(sb_q.size()), 32'd0);

    // Adjust to 59:59 and wrap.
    do_reset();
    a_adj = 1'b1;
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    a_write(2'd3, 4'd5); a_write(2'd2, 4'd9); a_write(2'd1, 4'd5); a_write(2'd0, 4'd9);
    check("adj_5959", 32'(a_count), 32'h5959);
    a_adj = 1'b0;
    cyc(1);
    check("adj_ss_ignored", 32'(a_running), 32'd0);
    push_exp(16'h0000, 1'b0);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(4);
    check("wrap_count", 32'(a_count), 32'h0000);
    check("wrap_running", 32'(a_running), 32'd1);
    check("wrap_tick", 32'(a_tick), 32'd1);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(1);

    // Clamp and countdown to expiry.
    do_reset();
    a_adj = 1'b1;
    a_write(2'd1, 4'd9);
    check("clamp_odd", 32'(a_count), 32'h0050);
    a_write(2'd1, 4'd0);
    a_write(2'd0, 4'd15);
    check("clamp_even", 32'(a_count), 32'h0009);
    a_write(2'd0, 4'd7);
    check("adj_0007", 32'(a_count), 32'h0007);
    for (int i = 6; i >= 1; i--) push_exp(16'(i), 1'b0);
    push_exp(16'h0000, 1'b1);
    a_adj = 1'b0; a_down = 1'b1;
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(27);
    check("down_at_one", 32'(a_count), 32'h0001);
    check("down_not_expired", 32'(a_expired), 32'd0);
    cyc(1);
    check("down_zero", 32'(a_count), 32'h0000);
    check("down_expired", 32'(a_expired), 32'd1);
    check("down_stopped", 32'(a_running), 32'd0);
    cyc(1);
    check("expired_one_cycle", 32'(a_expired), 32'd0);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(8);
    check("zero_ss_ignored", 32'(a_running), 32'd0);
    check("zero_hold", 32'(a_count), 32'h0000);
    a_down = 1'b0;

    // Lap hold, then clear together with start_stop on a terminal cycle.
    do_reset();
    for (int i = 1; i <= 5; i++) push_exp(to_bcd4(i), 1'b0);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(12);
    check("lap_pre_count", 32'(a_count), 32'h0003);
    a_lap = 1'b1; cyc(1); a_lap = 1'b0;
    check("lap_active", 32'(a_lap_active), 32'd1);
    check("lap_digits", 32'(a_digits), 32'h0003);
    cyc(8);
    check("lap_count_runs", 32'(a_count), 32'h0005);
    check("lap_digits_frozen", 32'(a_digits), 32'h0003);
    a_lap = 1'b1; cyc(1); a_lap = 1'b0;
    check("lap_release", 32'(a_lap_active), 32'd0);
    check("lap_digits_track", 32'(a_digits), 32'h0005);
    a_lap = 1'b1; cyc(1); a_lap = 1'b0;
    check("lap_again", 32'(a_lap_active), 32'd1);
    a_clr = 1'b1; a_ss = 1'b1; cyc(1); a_clr = 1'b0; a_ss = 1'b0;
    check("clr_count", 32'(a_count), 32'h0000);
    check("clr_running", 32'(a_running), 32'd0);
    check("clr_lap", 32'(a_lap_active), 32'd0);
    check("clr_no_tick", 32'(a_tick), 32'd0);

    // Pause mid-prescaler, resume, then change direction mid-run.
    push_exp(16'h0001, 1'b0); push_exp(16'h0002, 1'b0); push_exp(16'h0001, 1'b0);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(2);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    cyc(10);
    check("pause_hold", 32'(a_count), 32'h0000);
    check("pause_running", 32'(a_running), 32'd0);
    a_ss = 1'b1; cyc(1); a_ss = 1'b0;
    check("resume_running", 32'(a_running), 32'd1);
    cyc(1);
    check("resume_first_step", 32'(a_count), 32'h0001);
    cyc(3);
    check("resume_hold", 32'(a_count), 32'h0001);
    cyc(1);
    check("resume_second_step", 32'(a_count), 32'h0002);
    a_down = 1'b1;
    cyc(3);
    check("dir_change_no_step", 32'(a_count), 32'h0002);
    cyc(1);
    check("dir_change_step", 32'(a_count), 32'h0001);
    cyc(3);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("midrun_rst_count", 32'(a_count), 32'h0000);
    check("midrun_rst_flags", 32'({a_running, a_lap_active, a_tick, a_expired}), 32'h0);
    a_down = 1'b0;
    cyc(2);
    check("sb_drained_a", 32'(sb_q.size()), 32'd0);

    // Six digits, one step per cycle.
    do_reset();
    b_adj = 1'b1;
    b_write(3'd6, 4'd3);
    check("b_sel_out_of_range", 32'(b_count), 32'h0);
    b_write(3'd4, 4'd12);
    check("b_clamp_even", 32'(b_count), 32'h090000);
    b_write(3'd5, 4'd9);
    check("b_clamp_odd", 32'(b_count), 32'h590000);
    b_adj = 1'b0;
    do_reset();
    t0 = n_ticks_b;
    b_ss = 1'b1; cyc(1); b_ss = 1'b0;
    cyc(3600);
    check("b_count_1h", 32'(b_count), 32'h010000);
    check("b_running", 32'(b_running), 32'd1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("b_rst_count", 32'(b_count), 32'h0);
    check("b_rst_digits", 32'(b_digits), 32'h0);
    check("b_rst_flags", 32'({b_running, b_lap_active, b_tick, b_expired}), 32'h0);
    cyc(1);
    check("b_tick_total", 32'(n_ticks_b - t0), 32'd3600);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of BCD digits; even index radix 10, odd index radix 6 (ss, mm, ...).
REQ-002 Parameter TICK_DIV, default 100_000_000: clk cycles per count step (1 Hz at 100 MHz).
REQ-003 Derived constant SEL_W = max(1, clog2(NUM_DIGITS)); not overridable.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start_stop  in  1  single-cycle pulse (debounced upstream); toggles run flag.
REQ-007 clear  in  1  single-cycle pulse; zeroes count, stops, releases lap.
REQ-008 lap  in  1  single-cycle pulse; toggles lap hold.
REQ-009 down  in  1  level; 1 = countdown, 0 = count up.
REQ-010 adj  in  1  level; adjust mode, forces pause.
REQ-011 adj_sel  in  SEL_W  digit index to write.
REQ-012 adj_we  in  1  single-cycle write strobe, honoured only while adj=1.
REQ-013 adj_val  in  4  value to write.
REQ-014 count  out  4*NUM_DIGITS  live packed BCD, digit 0 in bits [3:0].
REQ-015 digits  out  4*NUM_DIGITS  display value: lap snapshot when lap_active, else count.
REQ-016 running  out  1  run_flag AND NOT adj.
REQ-017 lap_active  out  1  lap hold in effect.
REQ-018 tick  out  1  one-cycle pulse in the cycle count changes due to timing.
REQ-019 expired  out  1  one-cycle pulse when countdown reaches all-zero.

Function
REQ-020 Prescaler counts 0..TICK_DIV-1 only while running; terminal value produces a step and wraps to 0 on the next cycle.
REQ-021 Pause (start_stop or adj) holds prescaler value; clear and rst zero it.
REQ-022 Step, up: digit 0 increments; a digit at radix-1 wraps to 0 and carries; all-max (59:59 at default) wraps to all-zero and keeps running.
REQ-023 Step, down: digit 0 decrements; a digit at 0 borrows and loads radix-1.
REQ-024 Down step reaching all-zero: count = 0, run_flag cleared same edge, expired pulses one cycle later together with tick.
REQ-025 start_stop while down=1 and count all-zero: ignored; start_stop while adj=1: ignored.
REQ-026 Count updates the cycle after the terminal prescaler cycle; tick aligned with the count change.
REQ-027 Adjust write: adj=1 and adj_we=1 writes digit adj_sel; adj_val >= radix is clamped to radix-1; adj_sel >= NUM_DIGITS ignored.
REQ-028 lap pulse while lap_active=0 snapshots count into lap register and sets lap_active; while 1 clears lap_active; count keeps running throughout.
REQ-029 Priority in one cycle: rst > clear > adjust write > timing step > start_stop > lap.
REQ-030 clear with start_stop same cycle: run_flag = 0; clear with lap same cycle: lap_active = 0.
REQ-031 down changed mid-run: takes effect at next step; no count change on the toggle itself.

Reset
REQ-032 rst: count = 0, lap register = 0, prescaler = 0, run_flag = 0, lap_active = 0, tick = 0, expired = 0; digits = 0, running = 0 on the following cycle.
REQ-033 rst mid-run or mid-lap aborts everything; no tick or expired pulse is emitted for the reset cycle.

Structure
REQ-034 Shared package stopwatch_pkg holds RADIX_EVEN = 10, RADIX_ODD = 6, BCD_W = 4, and function radix_of(index).
REQ-035 One sub-module bcd_digit (radix parameter; inc, dec, load, carry/borrow out), instantiated NUM_DIGITS times in a generate loop.
REQ-036 Prescaler, run/lap control and output muxing live in stopwatch_core; no other hierarchy.

Verification (TICK_DIV = 4, NUM_DIGITS = 4 unless noted)
REQ-037 rst, start_stop, run 240 cycles -> count = 01:00 (0x0100), 60 tick pulses, no expired.
REQ-038 adj=1, write sel 3 val 5, sel 2 val 9, sel 1 val 5, sel 0 val 9, adj=0, start_stop, 4 cycles -> count wraps to 0x0000, running = 1.
REQ-039 adj write sel 1 val 9 -> digit 1 = 5 (clamp); sel 0 val 7 then down=1, start_stop -> expired pulses after 28 cycles, count = 0, running = 0; further start_stop ignored.
REQ-040 Running, lap at 00:03 -> digits frozen at 0x0003 while count advances; second lap -> digits track count.
REQ-041 clear and start_stop same cycle while running -> count = 0, running = 0, lap_active = 0; pause mid-prescaler then resume -> next tick after remaining cycles only.
REQ-042 NUM_DIGITS = 6, TICK_DIV = 1: 3600 steps -> count = 0x010000; rst asserted mid-run -> all outputs 0 next cycle.
